proc_control_unit: RTL
======================

// Module: proc_control_unit
// PURPOSE
//  Control FSM for the 9-bit processor datapath; generates the bus-mux select lines and register load enables.
//  Decodes the instruction register and drives the bus-driver selects consumed by the bus mux: R_out one-hot, G_out, DIN_out.
//  Drives the load enables R_in one-hot, A_in, G_in, IR_in and the ALU mode AddSub.
//  Runs one instruction per Run pulse: 2 cycles for mv/mvi, 4 cycles for add/sub; pulses Done on the last step.
// PARAMETERS
//  OPC_W      3  opcode field width (IR[8:6])
//  REG_SEL_W  3  register-index field width; NUM_REGS = 2**REG_SEL_W = 8
// PORTS
//  Clock    in   1   single system clock; all state updates on rising edge
//  Resetn   in   1   asynchronous, active-low reset
//  Run      in   1   start request, sampled only in step T0
//  IR       in   9   registered instruction: [8:6] opcode, [5:3] X, [2:0] Y
//  G_nz     in   1   G register != 0; used only with CTRL_MVNZ_EN
//  R_out    out  8   one-hot bus select, R0..R7 onto bus
//  G_out    out  1   G onto bus
//  DIN_out  out  1   DIN onto bus
//  R_in     out  8   one-hot load enable, R0..R7 from bus
//  A_in     out  1   load A from bus
//  G_in     out  1   load G from ALU
//  IR_in    out  1   load IR from DIN
//  AddSub   out  1   ALU mode: 0 = A+bus, 1 = A-bus
//  Done     out  1   instruction complete; 1-cycle pulse
//  tstep    out  2   current step (T0=0..T3=3), for debug/verification
// BEHAVIOUR
//  - State: 2-bit step register, T0..T3. Resetn=0 forces T0 asynchronously; this also aborts any in-flight instruction.
//  - Outputs are decoded combinationally from step, IR, Run and G_nz. All outputs are 0 while in T0 with Run=0, hence 0 in reset.
//  - T0: if Run=1, assert IR_in and go to T1 next edge; otherwise stay in T0 with all outputs 0.
//  - T1, opcode 000, mv Rx,Ry: R_out=1<<Y, R_in=1<<X, Done=1; go to T0.
//  - T1, opcode 001, mvi Rx,#D: DIN_out=1, R_in=1<<X, Done=1; go to T0. Immediate word is on DIN this cycle.
//  - T1, opcode 010 add / 011 sub: R_out=1<<X, A_in=1; go to T2.
//  - T2, add/sub: R_out=1<<Y, G_in=1, AddSub=(opcode==011); go to T3.
//  - T3, add/sub: G_out=1, R_in=1<<X, Done=1; go to T0.
//  - Opcodes 101-111, and 100 without the macro: NOP. T1 asserts Done only, then T0.
//  - Invariant every cycle: at most one of {any R_out bit, G_out, DIN_out} is set; R_out and R_in are each one-hot or zero.
//  - X==Y is legal: mv R3,R3 sets R_out=R_in=0x08 in the same cycle; add R3,R3 doubles R3.
//  - Run is ignored outside T0. Run held high re-fetches in the cycle after Done, giving back-to-back execution.
//  - IR must stay stable from T1 until Done. The external IR register loads only when IR_in=1.
//  - T2/T3 are unreachable for non-add/sub opcodes. An illegal step, e.g. after SEU, returns to T0 on the next edge with outputs 0.
// CONFIGURATION
//  Macro CTRL_MVNZ_EN.
//  - Defined: opcode 100 = mvnz Rx,Ry. In T1: R_out=1<<Y; R_in=1<<X only if G_nz=1; Done=1; go to T0.
//  - Undefined: opcode 100 is a NOP (Done only at T1), and G_nz is ignored.
// TESTING
//  1. Reset: Resetn=0 with Run=1 and IR=0x0C5 -> tstep=0 and all outputs 0. Release -> IR_in=1 in the same cycle as Run.
//  2. mv R2,R5 (IR=9'b000_010_101): T1 -> R_out=0x20, R_in=0x04, Done=1; back in T0 next cycle.
//  3. mvi R7,#x (IR=9'b001_111_000): T1 -> DIN_out=1, R_in=0x80, Done=1; R_out=0 and G_out=0.
//  4. sub R1,R0 (IR=9'b011_001_000): T1 R_out=0x02,A_in=1; T2 R_out=0x01,G_in=1,AddSub=1; T3 G_out=1,R_in=0x02,Done=1.
//  5. Resetn pulsed low during T2 of an add -> immediate tstep=0 with all outputs 0; the following Run re-fetches cleanly.
//  6. With CTRL_MVNZ_EN, IR=9'b100_011_001: G_nz=0 -> R_in=0, Done=1; G_nz=1 -> R_out=0x02, R_in=0x08, Done=1.

Source files
------------

// File: rtl/proc_control_unit.sv
// Step-sequenced control unit for the 9-bit processor: decodes IR into bus selects and load enables.
// Optional mvnz instruction on opcode 100 enabled by defining CTRL_MVNZ_EN.
module proc_control_unit #(
    parameter int unsigned OPC_W     = 3,
    parameter int unsigned REG_SEL_W = 3,
    localparam int unsigned NUM_REGS = 2 ** REG_SEL_W,
    localparam int unsigned IR_W     = OPC_W + 2 * REG_SEL_W
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic [IR_W-1:0]     IR,
    input  logic                G_nz,
    output logic [NUM_REGS-1:0] R_out,
    output logic                G_out,
    output logic                DIN_out,
    output logic [NUM_REGS-1:0] R_in,
    output logic                A_in,
    output logic                G_in,
    output logic                IR_in,
    output logic                AddSub,
    output logic                Done,
    output logic [1:0]          tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    localparam logic [OPC_W-1:0] OP_MV   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_MVI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(3);
`ifdef CTRL_MVNZ_EN
    localparam logic [OPC_W-1:0] OP_MVNZ = OPC_W'(4);
`endif

    step_e                r_step;
    step_e                w_step_next;
    logic [OPC_W-1:0]     w_opc;
    logic [REG_SEL_W-1:0] w_x;
    logic [REG_SEL_W-1:0] w_y;
    logic [NUM_REGS-1:0]  w_x_oh;
    logic [NUM_REGS-1:0]  w_y_oh;
    logic                 w_is_addsub;

    assign w_opc       = IR[IR_W-1 -: OPC_W];
    assign w_x         = IR[2*REG_SEL_W-1 -: REG_SEL_W];
    assign w_y         = IR[REG_SEL_W-1:0];
    assign w_x_oh      = NUM_REGS'(1) << w_x;
    assign w_y_oh      = NUM_REGS'(1) << w_y;
    assign w_is_addsub = (w_opc == OP_ADD) || (w_opc == OP_SUB);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_next;
        end
    end

    always_comb begin
        w_step_next = T0;
        R_out       = '0;
        G_out       = 1'b0;
        DIN_out     = 1'b0;
        R_in        = '0;
        A_in        = 1'b0;
        G_in        = 1'b0;
        IR_in       = 1'b0;
        AddSub      = 1'b0;
        Done        = 1'b0;

        unique case (r_step)
            T0: begin
                if (Run) begin
                    IR_in       = 1'b1;
                    w_step_next = T1;
                end
            end
            T1: begin
                if (w_opc == OP_MV) begin
                    R_out = w_y_oh;
                    R_in  = w_x_oh;
                    Done  = 1'b1;
                end else if (w_opc == OP_MVI) begin
                    DIN_out = 1'b1;
                    R_in    = w_x_oh;
                    Done    = 1'b1;
                end else if (w_is_addsub) begin
                    R_out       = w_x_oh;
                    A_in        = 1'b1;
                    w_step_next = T2;
`ifdef CTRL_MVNZ_EN
                end else if (w_opc == OP_MVNZ) begin
                    R_out = w_y_oh;
                    R_in  = G_nz ? w_x_oh : '0;
                    Done  = 1'b1;
`endif
                end else begin
                    Done = 1'b1;
                end
            end
            // T2/T3 with a non-add/sub opcode can only follow an upset; fall back to T0 silently.
            T2: begin
                if (w_is_addsub) begin
                    R_out       = w_y_oh;
                    G_in        = 1'b1;
                    AddSub      = (w_opc == OP_SUB);
                    w_step_next = T3;
                end
            end
            T3: begin
                if (w_is_addsub) begin
                    G_out = 1'b1;
                    R_in  = w_x_oh;
                    Done  = 1'b1;
                end
            end
            default: w_step_next = T0;
        endcase

        // Keep every output quiet while reset is held, even with Run high.
        if (!Resetn) begin
            R_out   = '0;
            G_out   = 1'b0;
            DIN_out = 1'b0;
            R_in    = '0;
            A_in    = 1'b0;
            G_in    = 1'b0;
            IR_in   = 1'b0;
            AddSub  = 1'b0;
            Done    = 1'b0;
        end
    end

    assign tstep = r_step;

endmodule
